audio_tone_arbiter: RTL and testbench
=====================================

# audio_tone_arbiter

Sequences and shares the single audio tone backend (square-wave/I2S note generator) between two requesters: the background-melody sequencer, enabled by `en_music`, and the hit sound effect, triggered by `hit`. It sits between the game/keyboard outputs (`hit`, `en_music`) and the audio backend. Each cycle it selects the winning source (SFX over music over silence) and hands the backend a tone via a ready-gated load handshake. The melody beat keeps running while the SFX pre-empts it, so the melody stays in time.

## Interface
- `BEAT_CYCLES`, default 25_000_000: clk cycles per melody note (0.25 s at 100 MHz).
- `SFX_CYCLES`, default 5_000_000: clk cycles per SFX note (50 ms).
- `clk`  in  1  system clock, 100 MHz.
- `rst`  in  1  reset; one clock; reset is asynchronous and active-low (`rst`=0 resets).
- `hit`  in  1  one-cycle pulse per successful key hit.
- `en_music`  in  1  level; melody requested while high.
- `dac_ready`  in  1  backend can accept a new tone this cycle.
- `tone_div`  out  20  issued tone half-period in clk cycles; 0 = silence.
- `tone_vol`  out  3  issued volume.
- `tone_src`  out  2  issued source: 00 idle, 01 music, 10 sfx.
- `tone_load`  out  1  one-cycle strobe; backend latches `tone_div`/`tone_vol` when high.
- `busy`  out  1  SFX FSM not IDLE.

## Operation
- Note codes and half-period dividers:
  - 0 = rest (div 0).
  - 1 = C4 191112; 2 = D4 170265; 3 = E4 151685; 4 = F4 143172; 5 = G4 127551; 6 = A4 113636; 7 = B4 101239.
  - SFX notes: C5 95557, G5 63776.
- Melody ROM: 16 entries, codes 1,1,5,5,6,6,5,0,4,4,3,3,2,2,1,0, indexed by 4-bit `idx`.
- Music sequencer:
  - While `en_music`=1, `beat_cnt` counts 0..BEAT_CYCLES-1.
  - On wrap, `idx` <= `idx`+1 (mod 16, 15→0).
  - While `en_music`=0, `beat_cnt`=0 and `idx`=0, so the melody always restarts from entry 0.
  - Advances regardless of SFX activity.
- SFX FSM, states IDLE → NOTE1 (C5) → NOTE2 (G5) → IDLE:
  - Each note state lasts exactly SFX_CYCLES cycles, counted by `sfx_cnt`.
  - `hit` in any state (including NOTE1/NOTE2) → NOTE1 with `sfx_cnt`=0 (retrigger, no queue).
  - `hit` on the final cycle of NOTE2 also retriggers; retrigger wins over exit.
- Desired tone, combinational from state registers:
  - SFX not IDLE: (SFX note div, vol 6, src 10).
  - Else if `en_music`: (ROM[`idx`] div, vol 3, src 01). A rest keeps src 01 with div 0.
  - Else: (0, 0, 00).
- Load handshake:
  - Issued registers hold `tone_div`/`tone_vol`/`tone_src`.
  - At an edge where desired ≠ issued (any field) and `dac_ready`=1: issued <= desired and `tone_load` <= 1.
  - Otherwise `tone_load` <= 0.
  - If `dac_ready`=0, the change stays pending. The newest desired value wins; intermediate values are dropped. No load is issued when desired equals issued.
- `tone_load` is never high for two consecutive cycles unless desired changes again in between.

## Timing
- Reset values: `tone_div`=0, `tone_vol`=0, `tone_src`=00, `tone_load`=0, `busy`=0; SFX IDLE; `idx`=0; `beat_cnt`=0; `sfx_cnt`=0.
- Reset asserted mid-SFX or mid-melody clears everything immediately (asynchronous). First load after release occurs only when desired ≠ 0.
- Hit latency, with `dac_ready`=1:
  - `hit` sampled at edge N → `busy`=1 after edge N.
  - Issued tone = C5 after edge N+1, with `tone_load` high for that one cycle.
  - G5 is issued SFX_CYCLES edges after C5. The return to music/silence is issued SFX_CYCLES edges after G5.
- Music:
  - `en_music` rising at edge N → ROM[0] loaded after edge N+1.
  - Each note change is loaded one edge after the `idx` change.
  - Consecutive equal notes produce no load.
- `en_music` falling with SFX idle → silence (0, 0, 00) loaded one edge later.
- `hit` and `en_music` toggling in the same cycle: SFX wins; the melody restarts at 0 underneath.
- `dac_ready` low for K cycles: the load occurs at the first edge with ready high, carrying the value desired at that edge.

## Test plan
Bench overrides: BEAT_CYCLES=8, SFX_CYCLES=4.
- Reset then idle 20 cycles → all outputs 0, no `tone_load`.
- `en_music`=1 at edge 0, ready tied high:
  - load div 191112, vol 3, src 01 at edge 1.
  - next load at edge 17 (191112→127551); none at edge 9 (repeat note).
  - `idx` wraps 15→0 after 128 cycles.
- Music playing, `hit` pulse:
  - C5 (95557, vol 6, src 10) loaded 2 edges after the pulse; G5 4 edges later; the current melody note 4 edges after that.
  - `busy` high for exactly 8 cycles.
- `hit` again during NOTE2 → C5 reloaded 1 edge later; SFX extends for another 8 cycles; `busy` never drops.
- `dac_ready`=0 across the C5→G5 transition, then raised after the SFX ends → a single load of the melody/silence value; C5 issued earlier remains until then; no G5 load.
- Async reset pulse mid-SFX (between edges) → outputs 0 immediately, `busy`=0. After release with `en_music`=1, melody resumes from `idx` 0.

Source files
------------

// File: rtl/audio_tone_arbiter.sv
// audio_tone_arbiter: shares one tone backend between the melody sequencer and the hit SFX via a ready-gated load handshake
module audio_tone_arbiter #(
    parameter int BEAT_CYCLES = 25_000_000,
    parameter int SFX_CYCLES  = 5_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hit,
    input  logic        en_music,
    input  logic        dac_ready,
    output logic [19:0] tone_div,
    output logic [2:0]  tone_vol,
    output logic [1:0]  tone_src,
    output logic        tone_load,
    output logic        busy
);
    localparam int BW = $clog2(BEAT_CYCLES + 1);
    localparam int SW = $clog2(SFX_CYCLES + 1);
    localparam logic [19:0] C5_DIV = 20'd95557;
    localparam logic [19:0] G5_DIV = 20'd63776;
    localparam logic [19:0] NOTE_DIV [8] = '{20'd0, 20'd191112, 20'd170265, 20'd151685,
                                             20'd143172, 20'd127551, 20'd113636, 20'd101239};
    localparam logic [2:0] MELODY [16] = '{3'd1, 3'd1, 3'd5, 3'd5, 3'd6, 3'd6, 3'd5, 3'd0,
                                           3'd4, 3'd4, 3'd3, 3'd3, 3'd2, 3'd2, 3'd1, 3'd0};

    typedef enum logic [1:0] {IDLE, NOTE1, NOTE2} sfx_state_t;

    sfx_state_t    state, state_nx;
    logic [SW-1:0] sfx_cnt, sfx_cnt_nx;
    logic [BW-1:0] beat_cnt;
    logic [3:0]    idx;
    logic          en_q;
    logic          sfx_last;
    logic [19:0]   sfx_div;
    logic [19:0]   des_div;
    logic [2:0]    des_vol;
    logic [1:0]    des_src;
    logic          change;

    // registered enable: melody tone appears one edge after en_music is sampled
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_q     <= 1'b0;
            beat_cnt <= '0;
            idx      <= '0;
        end else begin
            en_q <= en_music;
            if (!en_q) begin
                beat_cnt <= '0;
                idx      <= '0;
            end else if (beat_cnt == BW'(BEAT_CYCLES - 1)) begin
                beat_cnt <= '0;
                idx      <= idx + 4'd1;
            end else begin
                beat_cnt <= beat_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            sfx_cnt <= '0;
        end else begin
            state   <= state_nx;
            sfx_cnt <= sfx_cnt_nx;
        end
    end

    // a hit always restarts the effect, even on the last cycle of NOTE2
    always_comb begin
        sfx_last   = sfx_cnt == SW'(SFX_CYCLES - 1);
        state_nx   = state;
        sfx_cnt_nx = sfx_cnt + 1'b1;
        if (hit) begin
            state_nx   = NOTE1;
            sfx_cnt_nx = '0;
        end else if (state == IDLE) begin
            sfx_cnt_nx = '0;
        end else if (sfx_last) begin
            state_nx   = state == NOTE1 ? NOTE2 : IDLE;
            sfx_cnt_nx = '0;
        end
    end

    always_comb begin
        busy    = state != IDLE;
        sfx_div = state == NOTE1 ? C5_DIV : G5_DIV;
    end

    always_comb begin
        des_div = busy ? sfx_div : en_q ? NOTE_DIV[MELODY[idx]] : 20'd0;
        des_vol = busy ? 3'd6 : en_q ? 3'd3 : 3'd0;
        des_src = busy ? 2'b10 : en_q ? 2'b01 : 2'b00;
        change  = {des_div, des_vol, des_src} != {tone_div, tone_vol, tone_src};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tone_div  <= '0;
            tone_vol  <= '0;
            tone_src  <= '0;
            tone_load <= 1'b0;
        end else begin
            tone_load <= dac_ready && change;
            if (dac_ready && change) begin
                tone_div <= des_div;
                tone_vol <= des_vol;
                tone_src <= des_src;
            end
        end
    end
endmodule

// File: tb/tb_audio_tone_arbiter.sv
// tb_audio_tone_arbiter: directed bench with a load scoreboard keyed by edge number
module tb_audio_tone_arbiter;
    logic        clk = 1'b0;
    logic        rst, hit, en_music, dac_ready;
    logic [19:0] tone_div;
    logic [2:0]  tone_vol;
    logic [1:0]  tone_src;
    logic        tone_load, busy;

    typedef struct {int c; int div; int vol; int src;} exp_t;
    exp_t q[$];
    int cyc = 0;
    int m = 0;
    int total = 0;
    int bad = 0;
    int mel [16] = '{1, 1, 5, 5, 6, 6, 5, 0, 4, 4, 3, 3, 2, 2, 1, 0};
    int ndiv [8] = '{0, 191112, 170265, 151685, 143172, 127551, 113636, 101239};

    audio_tone_arbiter #(.BEAT_CYCLES(8), .SFX_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .hit(hit), .en_music(en_music), .dac_ready(dac_ready),
        .tone_div(tone_div), .tone_vol(tone_vol), .tone_src(tone_src),
        .tone_load(tone_load), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic push(input int t, input int d, input int v, input int s);
        q.push_back('{m + t, d, v, s});
    endtask

    task automatic go(input int t);
        while (cyc < m + t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_div"}, 32'(tone_div), 0);
        chk({tag, "_vol"}, 32'(tone_vol), 0);
        chk({tag, "_src"}, 32'(tone_src), 0);
        chk({tag, "_load"}, 32'(tone_load), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
    endtask

    always @(negedge clk) begin
        if (tone_load) begin
            if (q.size() == 0) chk("extra_load", 32'(tone_load), 0);
            else begin
                exp_t e;
                e = q.pop_front();
                chk("load_edge", cyc, e.c);
                chk("load_div", 32'(tone_div), e.div);
                chk("load_vol", 32'(tone_vol), e.vol);
                chk("load_src", 32'(tone_src), e.src);
            end
        end
    end

    initial begin
        rst = 1'b0; hit = 1'b0; en_music = 1'b0; dac_ready = 1'b1;
        #12 rst = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk_idle("reset_idle");
        en_music = 1'b1;
        m = cyc + 1;
        for (int k = 0; k <= 16; k++)
            if (k == 0 || mel[k % 16] != mel[(k + 15) % 16])
                push(k == 0 ? 1 : 8 * k + 1, ndiv[mel[k % 16]], 3, 1);
        go(131);
        hit = 1'b1;
        push(133, 95557, 6, 2);
        push(137, 63776, 6, 2);
        push(141, 191112, 3, 1);
        push(145, 127551, 3, 1);
        go(132);
        hit = 1'b0;
        for (int t = 132; t <= 139; t++) begin
            go(t);
            chk("sfx_busy", 32'(busy), 1);
        end
        go(140);
        chk("sfx_busy_end", 32'(busy), 0);
        go(149);
        hit = 1'b1;
        push(151, 95557, 6, 2);
        push(155, 63776, 6, 2);
        push(156, 95557, 6, 2);
        push(160, 63776, 6, 2);
        push(164, 113636, 3, 1);
        push(177, 127551, 3, 1);
        for (int t = 150; t <= 162; t++) begin
            go(t);
            hit = (t == 154);
            chk("retrig_busy", 32'(busy), 1);
        end
        go(163);
        chk("retrig_busy_end", 32'(busy), 0);
        go(179);
        hit = 1'b1;
        push(181, 95557, 6, 2);
        push(191, 0, 3, 1);
        push(193, 143172, 3, 1);
        go(180);
        hit = 1'b0;
        go(181);
        dac_ready = 1'b0;
        go(190);
        chk("hold_div", 32'(tone_div), 95557);
        chk("hold_src", 32'(tone_src), 2);
        chk("hold_busy", 32'(busy), 0);
        dac_ready = 1'b1;
        go(199);
        hit = 1'b1;
        push(201, 95557, 6, 2);
        go(200);
        hit = 1'b0;
        go(202);
        #2 rst = 1'b0;
        #1;
        chk_idle("async_rst");
        push(205, 191112, 3, 1);
        push(221, 127551, 3, 1);
        go(203);
        #2 rst = 1'b1;
        go(225);
        en_music = 1'b0;
        push(227, 0, 0, 0);
        go(230);
        chk("end_div", 32'(tone_div), 0);
        chk("end_busy", 32'(busy), 0);
        chk("queue_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
